// File: rtl/source_x.sv
// rtl/source_x.sv - in-order flush-completion response buffer, DEPTH entries, 1-cycle minimum latency.
// Optional saturating fail counter on io_fail_count when SOURCE_X_FAIL_CNT_EN is defined.
module source_x #(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_req_valid,
  output logic        io_req_ready,
  input  logic [12:0] io_req_bits_tag,
  input  logic [9:0]  io_req_bits_set,
  input  logic        io_req_bits_fail,
  output logic        io_x_valid,
  input  logic        io_x_ready,
  output logic [31:0] io_x_bits_address,
  output logic        io_x_bits_fail
`ifdef SOURCE_X_FAIL_CNT_EN
  ,
  output logic [7:0]  io_fail_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [31:0]   addr_mem_q [DEPTH];
  logic          fail_mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          enq, deq;
  logic [31:0]   enq_addr;

  // Readiness comes only from the registered count, so a full buffer never passes through.
  assign io_req_ready = (count_q != FULL_CNT);
  assign io_x_valid   = (count_q != '0);
  assign enq          = io_req_valid && io_req_ready;
  assign deq          = io_x_valid && io_x_ready;

  assign enq_addr = {io_req_bits_tag[12], 3'b000, io_req_bits_tag[11:0],
                     io_req_bits_set, 6'b000000};

  assign io_x_bits_address = addr_mem_q[rd_ptr_q];
  assign io_x_bits_fail    = fail_mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = wr_ptr_q + AW'(1);
    if (deq) rd_ptr_d = rd_ptr_q + AW'(1);
    case ({enq, deq})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is never reset; contents are only observed while io_x_valid is high.
  always_ff @(posedge clock) begin
    if (enq) begin
      addr_mem_q[wr_ptr_q] <= enq_addr;
      fail_mem_q[wr_ptr_q] <= io_req_bits_fail;
    end
  end

`ifdef SOURCE_X_FAIL_CNT_EN
  logic [7:0] fail_cnt_q, fail_cnt_d;

  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (deq && io_x_bits_fail && (fail_cnt_q != 8'hFF)) fail_cnt_d = fail_cnt_q + 8'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) fail_cnt_q <= '0;
    else       fail_cnt_q <= fail_cnt_d;
  end

  assign io_fail_count = fail_cnt_q;
`endif

endmodule
